// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage.
// Contents:
//   PC_W           - program-counter / address width (64)
//   NOP            - instruction word the decoder treats as a no-op
//   fetch_state_e  - fetch FSM states (FETCH, DROP, SKID)
//   sext_word_offset26/19 - sign-extend a word offset and scale it to bytes
package cpu_pkg;

    localparam int PC_W = 64;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        SKID  = 2'd2
    } fetch_state_e;

    // Unconditional-branch offset: 26-bit signed word count -> byte offset.
    function automatic logic [PC_W-1:0] sext_word_offset26(input logic [25:0] off);
        return {{(PC_W-28){off[25]}}, off, 2'b00};
    endfunction

    // Conditional-branch offset: 19-bit signed word count -> byte offset.
    function automatic logic [PC_W-1:0] sext_word_offset19(input logic [18:0] off);
        return {{(PC_W-21){off[18]}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/branch_target.sv
// Combinational redirect-target adder.
// Ports:
//   br_pc       in  64  PC of the branch in ID
//   br_addr26   in  26  unconditional word offset
//   cond_addr19 in  19  conditional word offset
//   uncond_br   in  1   selects br_addr26 (1) or cond_addr19 (0)
//   target      out 64  br_pc + sext(offset) * 4, wrapping modulo 2^64
module branch_target
    import cpu_pkg::*;
(
    input  logic [PC_W-1:0] br_pc,
    input  logic [25:0]     br_addr26,
    input  logic [18:0]     cond_addr19,
    input  logic            uncond_br,
    output logic [PC_W-1:0] target
);

    logic [PC_W-1:0] offset_s;

    // Select and scale the branch offset for the active branch kind.
    always_comb begin
        if (uncond_br) begin
            offset_s = sext_word_offset26(br_addr26);
        end else begin
            offset_s = sext_word_offset19(cond_addr19);
        end
    end

    assign target = br_pc + offset_s;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register, one-entry skid
// buffer and branch redirect handling.
// Ports:
//   clk, reset (async, active-low)
//   imem_req/imem_addr   out  fetch request and byte address
//   imem_rdata/imem_ack  in   returned word and its valid strobe
//   stall                in   hold IF/ID contents
//   br_taken, uncond_br, br_addr26, cond_addr19, br_pc  in  redirect request
//   if_id_instr/if_id_pc/if_id_valid  out  IF/ID register
// A branch always flushes IF/ID and wins over stall. A request whose data
// is still outstanding when a branch arrives is drained in DROP so that
// the memory never sees the address change before it acknowledges.
module fetch_stage
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ack,
    input  logic            stall,
    input  logic            br_taken,
    input  logic            uncond_br,
    input  logic [25:0]     br_addr26,
    input  logic [18:0]     cond_addr19,
    input  logic [PC_W-1:0] br_pc,
    output logic [31:0]     if_id_instr,
    output logic [PC_W-1:0] if_id_pc,
    output logic            if_id_valid
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            req_q, req_d;
    logic [PC_W-1:0] tgt_q, tgt_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic [PC_W-1:0] skid_pc_q, skid_pc_d;
    logic            skid_valid_q, skid_valid_d;
    logic [31:0]     ifid_instr_q, ifid_instr_d;
    logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
    logic            ifid_valid_q, ifid_valid_d;

    logic [PC_W-1:0] target_s;
    logic            ack_s;

    branch_target u_branch_target (
        .br_pc       (br_pc),
        .br_addr26   (br_addr26),
        .cond_addr19 (cond_addr19),
        .uncond_br   (uncond_br),
        .target      (target_s)
    );

    // An ack only counts against a request actually on the bus; this also
    // drops acks seen in the first cycle after reset and while in SKID.
    assign ack_s = imem_ack & req_q;

    // Next-state, PC, skid and IF/ID update logic.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;

        // Hold under stall, otherwise a bubble unless something loads below.
        if (stall) begin
            ifid_instr_d = ifid_instr_q;
            ifid_pc_d    = ifid_pc_q;
            ifid_valid_d = ifid_valid_q;
        end else begin
            ifid_instr_d = NOP;
            ifid_pc_d    = {PC_W{1'b0}};
            ifid_valid_d = 1'b0;
        end

        case (state_q)
            FETCH: begin
                if (br_taken) begin
                    // With no request outstanding there is nothing to drain.
                    if (ack_s || !req_q) begin
                        pc_d = target_s;
                    end else begin
                        tgt_d   = target_s;
                        state_d = DROP;
                    end
                end else if (ack_s) begin
                    pc_d = pc_q + 64'd4;
                    if (!stall || !ifid_valid_q) begin
                        ifid_instr_d = imem_rdata;
                        ifid_pc_d    = pc_q;
                        ifid_valid_d = 1'b1;
                    end else begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pc_q;
                        skid_valid_d = 1'b1;
                        state_d      = SKID;
                    end
                end else begin
                    pc_d = pc_q;
                end
            end
            DROP: begin
                if (br_taken) begin
                    // The newest redirect wins, even on the draining ack.
                    if (ack_s) begin
                        pc_d    = target_s;
                        state_d = FETCH;
                    end else begin
                        tgt_d = target_s;
                    end
                end else if (ack_s) begin
                    pc_d    = tgt_q;
                    state_d = FETCH;
                end else begin
                    state_d = DROP;
                end
            end
            SKID: begin
                if (br_taken) begin
                    skid_valid_d = 1'b0;
                    pc_d         = target_s;
                    state_d      = FETCH;
                end else if (!stall) begin
                    ifid_instr_d = skid_instr_q;
                    ifid_pc_d    = skid_pc_q;
                    ifid_valid_d = skid_valid_q;
                    skid_valid_d = 1'b0;
                    state_d      = FETCH;
                end else begin
                    state_d = SKID;
                end
            end
            default: begin
                state_d      = FETCH;
                skid_valid_d = 1'b0;
            end
        endcase

        // Redirect flushes IF/ID regardless of stall or state.
        if (br_taken) begin
            ifid_instr_d = NOP;
            ifid_pc_d    = {PC_W{1'b0}};
            ifid_valid_d = 1'b0;
        end else begin
            ifid_valid_d = ifid_valid_d;
        end

        // Request is registered so it stays low throughout reset.
        req_d = (state_d != SKID);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= FETCH;
            pc_q         <= {PC_W{1'b0}};
            req_q        <= 1'b0;
            tgt_q        <= {PC_W{1'b0}};
            skid_instr_q <= NOP;
            skid_pc_q    <= {PC_W{1'b0}};
            skid_valid_q <= 1'b0;
            ifid_instr_q <= NOP;
            ifid_pc_q    <= {PC_W{1'b0}};
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_q        <= req_d;
            tgt_q        <= tgt_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign if_id_instr = ifid_instr_q;
    assign if_id_pc    = ifid_pc_q;
    assign if_id_valid = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage. The reference model is the architectural
// instruction stream: after reset or a taken branch the decoder must see the
// words at consecutive addresses starting from 0 or the branch target.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_ack = 1'b0;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic        uncond_br = 1'b0;
    logic [25:0] br_addr26 = 26'h0;
    logic [18:0] cond_addr19 = 19'h0;
    logic [63:0] br_pc = 64'h0;
    logic [31:0] if_id_instr;
    logic [63:0] if_id_pc;
    logic        if_id_valid;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .stall       (stall),
        .br_taken    (br_taken),
        .uncond_br   (uncond_br),
        .br_addr26   (br_addr26),
        .cond_addr19 (cond_addr19),
        .br_pc       (br_pc),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] next_pc = 64'h0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_deliv = 0;
    int          wait_cnt = 0;
    bit          rand_lat = 1'b0;
    bit          hold_ack = 1'b0;
    bit          stray_ack = 1'b0;

    function automatic logic [31:0] word(input logic [63:0] a);
        return a[31:0] ^ a[63:32];
    endfunction

    function automatic logic [63:0] model_target(input logic unc, input logic [25:0] a26,
                                                 input logic [18:0] c19, input logic [63:0] bpc);
        longint off;
        if (unc) off = longint'($signed(a26));
        else     off = longint'($signed(c19));
        return bpc + 64'(off * 4);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs and the memory response at negedge, update the
    // reference stream at the following posedge.
    task automatic cycle(input logic st, input logic br, input logic unc,
                         input logic [25:0] a26, input logic [18:0] c19, input logic [63:0] bpc);
        logic was_req;
        @(negedge clk);
        was_req = imem_req;
        if (imem_req) begin
            if (wait_cnt == 0 && !hold_ack) begin
                imem_ack   = 1'b1;
                imem_rdata = word(imem_addr);
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                if (wait_cnt > 0) wait_cnt--;
            end
        end else begin
            imem_ack   = stray_ack && ($urandom_range(0, 3) == 0);
            imem_rdata = $urandom;
        end
        stall = st; br_taken = br; uncond_br = unc;
        br_addr26 = a26; cond_addr19 = c19; br_pc = bpc;
        @(posedge clk);
        if (was_req && imem_ack) wait_cnt = rand_lat ? int'($urandom_range(0, 2)) : 0;
        if (br) begin
            exp_q.delete();
            next_pc = model_target(unc, a26, c19, bpc);
        end
        while (exp_q.size() < 4) begin
            exp_q.push_back('{pc: next_pc, instr: word(next_pc)});
            next_pc = next_pc + 64'd4;
        end
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 26'h0, 19'h0, 64'h0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        next_pc  = 64'h0;
        wait_cnt = 0;
        hold_ack = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   {63'h0, imem_req}, 64'h0);
        chk({tag, "_addr"},  imem_addr, 64'h0);
        chk({tag, "_valid"}, {63'h0, if_id_valid}, 64'h0);
        chk({tag, "_instr"}, {32'h0, if_id_instr}, 64'h0);
        chk({tag, "_pc"},    if_id_pc, 64'h0);
    endtask

    // Release reset at a negedge with idle inputs and check the first request.
    task automatic release_reset(input string tag);
        @(negedge clk);
        stall = 1'b0; br_taken = 1'b0; imem_ack = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #2;
        chk({tag, "_first_req"},  {63'h0, imem_req}, 64'h1);
        chk({tag, "_first_addr"}, imem_addr, 64'h0);
    endtask

    // Monitor: classify every post-edge IF/ID value and check it.
    bit prev_valid = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                prev_valid = 1'b0;
            end else begin
                if (br_taken) begin
                    chk("flush_valid", {63'h0, if_id_valid}, 64'h0);
                    chk("flush_instr", {32'h0, if_id_instr}, 64'h0);
                    chk("flush_pc",    if_id_pc, 64'h0);
                end else if (if_id_valid && !(stall && prev_valid)) begin
                    n_deliv++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_delivery", if_id_pc, 64'hDEAD);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("deliver_pc",    if_id_pc, e.pc);
                        chk("deliver_instr", {32'h0, if_id_instr}, {32'h0, e.instr});
                    end
                end else if (!if_id_valid) begin
                    chk("bubble_instr", {32'h0, if_id_instr}, 64'h0);
                    chk("bubble_pc",    if_id_pc, 64'h0);
                end
                prev_valid = if_id_valid;
            end
        end
    end

    initial begin
        int lim;
        // Reset with an ack on the bus; it must be dropped.
        reset = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        model_reset();
        release_reset("rst");

        // Zero-wait memory: stream 0,4,8 then stall with ack on 12 (skid).
        lim = 0;
        while (!(if_id_valid && if_id_pc == 64'h8) && lim < 20) begin
            idle(1);
            lim++;
        end
        chk("reach_pc8", {63'h0, (lim < 20)}, 64'h1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 26'h0, 19'h0, 64'h0);
            chk("skid_hold_pc", if_id_pc, 64'h8);
            chk("skid_req_low", {63'h0, imem_req}, 64'h0);
        end
        idle(1);
        chk("skid_release_pc",   if_id_pc, 64'hC);
        chk("skid_release_addr", imem_addr, 64'h10);
        chk("skid_release_req",  {63'h0, imem_req}, 64'h1);

        // Unconditional branch, negative offset, ack present.
        cycle(1'b0, 1'b1, 1'b1, 26'h3FFFFFE, 19'h0, 64'h20);
        chk("uncond_addr", imem_addr, 64'h18);
        idle(3);

        // Conditional branch with the ack two cycles late.
        hold_ack = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, 26'h0, 19'h4, 64'h40);
        idle(2);
        chk("drop_req_held", {63'h0, imem_req}, 64'h1);
        hold_ack = 1'b0;
        idle(1);
        chk("drop_addr", imem_addr, 64'h50);
        idle(1);

        // Enter SKID, then branch while stalled.
        cycle(1'b1, 1'b0, 1'b0, 26'h0, 19'h0, 64'h0);
        chk("skid2_req_low", {63'h0, imem_req}, 64'h0);
        cycle(1'b1, 1'b1, 1'b0, 26'h0, 19'h7FFFF, 64'h100);
        chk("skid_br_addr", imem_addr, 64'hFC);
        chk("skid_br_req",  {63'h0, imem_req}, 64'h1);
        idle(3);

        // PC wrap past the top of the address space.
        cycle(1'b0, 1'b1, 1'b1, 26'h2, 19'h0, 64'hFFFF_FFFF_FFFF_FFF0);
        chk("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        idle(6);

        // Reset in the middle of DROP.
        hold_ack = 1'b1;
        cycle(1'b0, 1'b1, 1'b1, 26'h10, 19'h0, 64'h200);
        idle(1);
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("drop_reset");
        model_reset();
        release_reset("drop_rst");
        idle(4);

        // Randomized traffic.
        rand_lat  = 1'b1;
        stray_ack = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] bpc;
            bpc = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 7) == 0) bpc = 64'hFFFF_FFFF_FFFF_FFE0 | bpc[4:0];
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, 1'($urandom),
                  26'($urandom), 19'($urandom), bpc);
        end
        stray_ack = 1'b0;
        idle(10);
        chk("progress", {63'h0, (n_deliv >= 100)}, 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have ports: imem_req  out  1 (fetch request); imem_addr  out  64 (byte address of the word being fetched).
REQ-004 SHALL have ports: imem_rdata  in  32 (returned word); imem_ack  in  1 (rdata valid). imem_ack SHALL be allowed in the same cycle as imem_req, or any later cycle.
REQ-005 SHALL have port: stall  in  1  hazard hold; when 1, the IF/ID register SHALL keep its current contents.
REQ-006 SHALL have ports: br_taken  in  1; uncond_br  in  1; br_addr26  in  26; cond_addr19  in  19; br_pc  in  64 (PC of the branch currently in ID).
REQ-007 SHALL have ports: if_id_instr  out  32; if_id_pc  out  64; if_id_valid  out  1.

Function
REQ-008 SHALL compute the redirect target as br_pc + (sign-extended offset << 2). The offset SHALL be br_addr26 when uncond_br=1, and cond_addr19 otherwise. Addition SHALL wrap modulo 2^64.
REQ-009 SHALL implement FSM states FETCH, DROP and SKID.
REQ-010 FETCH: SHALL drive imem_req=1 with imem_addr=pc, holding imem_addr stable until imem_ack.
REQ-011 FETCH, ack, no br_taken, IF/ID free (stall=0 or if_id_valid=0): SHALL load IF/ID with {imem_rdata, pc, valid=1}, set pc <= pc+4, and stay in FETCH (one-cycle fetch latency).
REQ-012 FETCH, ack, stall=1 and if_id_valid=1: SHALL capture {imem_rdata, pc} in a one-entry skid buffer, set pc <= pc+4, and go to SKID.
REQ-013 SKID: SHALL drive imem_req=0. When stall=0, SHALL move the skid entry into IF/ID and return to FETCH.
REQ-014 br_taken=1 in FETCH with imem_ack=1: SHALL discard imem_rdata, set pc <= target, and stay in FETCH.
REQ-015 br_taken=1 in FETCH with imem_ack=0: SHALL latch the target and go to DROP.
REQ-016 DROP: SHALL keep imem_req=1 on the old address until imem_ack, discard that data, load pc with the latched target, and go to FETCH. A further br_taken while in DROP SHALL overwrite the latched target.
REQ-017 br_taken=1 in SKID: SHALL invalidate the skid entry, set pc <= target, and go to FETCH.
REQ-018 Any br_taken=1 SHALL flush IF/ID on the same edge: if_id_valid=0, if_id_instr=NOP, if_id_pc=0. br_taken SHALL take priority over stall.
REQ-019 When if_id_valid=0, if_id_instr SHALL equal NOP (32'h00000000), which the decoder treats as a no-op.
REQ-020 When stall=0 and no instruction is accepted in a cycle, IF/ID SHALL become the bubble {NOP, 0, valid=0}.
REQ-021 imem_ack while in SKID SHALL be ignored.
REQ-022 pc SHALL wrap from 64'hFFFF_FFFF_FFFF_FFFC to 0.

Reset
REQ-023 While reset=0, asynchronously: pc=0, state=FETCH, skid invalid, latched target=0, imem_req=0, imem_addr=0, if_id_valid=0, if_id_instr=NOP, if_id_pc=0.
REQ-024 SHALL assert imem_req on the first rising edge after reset deasserts. An ack arriving during reset SHALL be dropped.
REQ-025 Reset asserted mid-DROP or mid-SKID SHALL discard all pending state; fetch SHALL restart at address 0.

Structure
REQ-026 SHALL place the following in shared package cpu_pkg: the fetch-state enum (FETCH, DROP, SKID), the NOP constant, and the PC width (64).
REQ-027 SHALL place target computation in combinational sub-module branch_target (inputs br_pc, br_addr26, cond_addr19, uncond_br; output target).
REQ-028 SHALL contain all remaining sequential logic in fetch_stage; no latches.

Verification
REQ-029 Zero-wait memory, ack every cycle, word at address a = a: after reset, IF/ID SHALL show pc 0, 4, 8 on consecutive cycles with instr equal to pc.
REQ-030 stall=1 for 3 cycles while IF/ID holds pc 8, ack on pc 12: IF/ID SHALL hold 8; the skid SHALL hold 12; imem_req SHALL drop. On stall release, IF/ID SHALL show 12 and the next request SHALL be 16.
REQ-031 br_taken=1, uncond_br=1, br_pc=0x20, br_addr26=26'h3FFFFFE: target SHALL be 0x18; IF/ID SHALL flush the same edge; the next imem_addr SHALL be 0x18.
REQ-032 br_taken=1, uncond_br=0, cond_addr19=4, br_pc=0x40, ack 2 cycles late: the FSM SHALL enter DROP, the late data SHALL be discarded, and the next imem_addr SHALL be 0x50.
REQ-033 br_taken and stall together while in SKID: the skid SHALL be cleared, IF/ID SHALL be flushed to NOP, and fetch SHALL resume at the target.
REQ-034 Reset asserted during DROP: outputs SHALL take reset values immediately; after release, the first imem_addr SHALL be 0.
